// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver with valid/ready byte output.
//
// The raw line is brought into the clk domain through a two-flop
// synchroniser. A falling edge on the synchronised line arms a start-bit
// check at mid-bit. Each data bit, the optional parity bit and the stop bit
// are then sampled one bit period apart, so every sample lands mid-bit.
// Each completed byte is held on data_rx with its error flags until it is
// accepted with valid && ready. If a new byte arrives before acceptance,
// the held byte is replaced and overrun is raised.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
//   BITS_N        data bits per frame, LSB first (5..9)
//   PARITY_TYPE   0 = none, 1 = odd, 2 = even
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   uart_in     raw serial line, idle high, asynchronous to clk
//   data_rx     received data word
//   valid       data_rx and the flags hold a byte not yet accepted
//   ready       consumer accepts on a cycle with valid && ready
//   parity_err  parity mismatch on the held byte (always 0 without parity)
//   frame_err   stop bit was sampled low on the held byte
//   overrun     a byte was overwritten before it was accepted
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(BITS_N);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BITS_N - 1);
    localparam logic             HAS_PARITY = (PARITY_TYPE != 0);
    // Odd parity requires the XOR over data and parity bit to be 1.
    localparam logic             PARITY_ODD = (PARITY_TYPE == 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q;
    logic [1:0]          sync_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [BITS_N-1:0]   shift_q;
    logic                par_bad_q;     // parity result of the frame in flight
    logic                stop_q;        // sampled stop bit of the frame in flight
    logic                done_q;        // one-cycle pulse: frame just finished
    logic [BITS_N-1:0]   data_rx_q;
    logic                valid_q;
    logic                parity_err_q;
    logic                frame_err_q;
    logic                overrun_q;

    logic rx_s;
    logic accept;

    assign rx_s   = sync_q[1];
    assign accept = valid_q && ready;

    // NOTE: every register below is updated with non-blocking assignments in
    // one clocked block, so each branch reads the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: synchroniser flops reset to the idle-high line level, so
            // the receiver never sees a phantom falling edge out of reset.
            sync_q       <= 2'b11;
            state_q      <= S_WAIT_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_q       <= 1'b1;
            done_q       <= 1'b0;
            data_rx_q    <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], uart_in};
            done_q <= 1'b0;

            case (state_q)
                // Stay here until the line is seen high, so a line stuck low
                // after reset or after a framing error cannot start a frame.
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end

                // Re-check the start bit at mid-bit; a high line here was a
                // glitch and is dropped without any flag.
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[BITS_N-1:1]};
                        if (idx_q == IDX_LAST) begin
                            state_q <= HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= ((^shift_q) ^ rx_s) != PARITY_ODD;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // The stop sample is at mid-bit, leaving half a bit of margin
                // to re-arm for a back-to-back start bit.
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        stop_q  <= rx_s;
                        done_q  <= 1'b1;
                        state_q <= rx_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: state_q <= S_WAIT_IDLE;
            endcase

            // Output holding register. A completing byte always wins; it
            // counts as an overrun only if the held byte is not leaving now.
            if (done_q) begin
                data_rx_q    <= shift_q;
                valid_q      <= 1'b1;
                parity_err_q <= HAS_PARITY && par_bad_q;
                frame_err_q  <= !stop_q;
                overrun_q    <= valid_q && !ready;
            end else if (accept) begin
                valid_q      <= 1'b0;
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

    assign data_rx    = data_rx_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
